// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and MEM/WB payload packing for pipe_stage_elastic
//
// Purpose: mode selectors, stall-vector polarity and the field layout used
// when the stage sits at the MEM->WB boundary.
// Ports: none (package).
package pipe_pkg;

  localparam int MODE_STALL   = 0;
  localparam int MODE_ELASTIC = 1;

  // Stall vector polarity: a 1 in a stage's bit stops that stage.
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // MEM/WB field packing; $bits(mem_wb_payload_t) is the PAYLOAD_W to use
  // when this stage replaces the old fixed-field latch.
  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic        llbit_we;
    logic        llbit_value;
    logic        cp0_reg_we;
    logic [4:0]  cp0_reg_write_addr;
    logic [31:0] cp0_reg_data;
  } mem_wb_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - 2-entry elastic store (main + skid) with valid/ready handshake
//
// Purpose: holds up to two entries in FIFO order; the main entry drives the
// outputs, the skid entry absorbs the one input accepted while main stalls.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           synchronous kill of both entries
//   in_valid/in_ready/in_payload     upstream handshake and data
//   out_valid/out_ready/out_payload  downstream handshake and data
//   fire_out        an entry is consumed downstream this cycle
module pipe_skid_buf #(
  parameter int PAYLOAD_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 fire_out
);

  logic                 main_valid;
  logic                 skid_valid;
  logic [PAYLOAD_W-1:0] main_data;
  logic [PAYLOAD_W-1:0] skid_data;
  logic                 fire_in;

  // in_ready comes straight from a flop, so out_ready never reaches the
  // upstream stage combinationally.
  assign in_ready = ~skid_valid;
  assign fire_in  = in_valid & ~skid_valid;
  assign fire_out = main_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!main_valid || fire_out) begin
      if (skid_valid) begin
        // Older skid entry moves up; in_ready was low so no input fired.
        main_valid <= 1'b1;
        main_data  <= skid_data;
        skid_valid <= 1'b0;
        skid_data  <= '0;
      end else begin
        main_valid <= fire_in;
        main_data  <= fire_in ? in_payload : '0;
      end
    end else if (fire_in) begin
      skid_valid <= 1'b1;
      skid_data  <= in_payload;
    end
  end

  assign out_valid   = main_valid;
  assign out_payload = main_data;

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - parametrised pipeline stage register, stall-vector or elastic mode
//
// Purpose: carries an opaque payload between two pipeline stages, with a
// synchronous flush and a count of entries consumed downstream.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           synchronous kill of all held entries
//   stall           pipeline stall vector (1 = stop), stall mode only
//   in_valid/in_ready/in_payload     upstream side
//   out_valid/out_ready/out_payload  downstream side (out_ready elastic only)
//   retire_cnt      wrapping count of consumed entries, cleared only by rst
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int PAYLOAD_W = 32,
  parameter int MODE      = 0,
  parameter int STALL_W   = 6,
  parameter int STAGE     = 4,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [CNT_W-1:0]     retire_cnt
);

  logic consume;

  if (MODE == MODE_ELASTIC) begin : g_elastic
    logic unused_stall;
    assign unused_stall = ^stall;

    pipe_skid_buf #(
      .PAYLOAD_W (PAYLOAD_W)
    ) u_skid (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_payload  (in_payload),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_payload (out_payload),
      .fire_out    (consume)
    );
  end else begin : g_stall
    logic                 st_valid;
    logic [PAYLOAD_W-1:0] st_data;
    logic                 stop_here;
    logic                 stop_next;
    logic                 unused_in;

    assign unused_in = out_ready ^ (^stall);
    assign stop_here = (stall[STAGE] == STOP);
    assign stop_next = (stall[STAGE+1] == STOP);

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        st_valid <= 1'b0;
        st_data  <= '0;
      end else if (!stop_here) begin
        st_valid <= in_valid;
        st_data  <= in_valid ? in_payload : '0;
      end else if (!stop_next) begin
        // This stage stopped but the next one runs: hand it a zero bubble.
        st_valid <= 1'b0;
        st_data  <= '0;
      end
      // Both stopped: hold.
    end

    assign in_ready    = (stall[STAGE] == NO_STOP);
    assign out_valid   = st_valid;
    assign out_payload = st_data;
    // The next stage takes the entry on any edge where it is not stopped.
    assign consume     = st_valid & ~stop_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt <= '0;
    end else if (consume && !flush) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - self-checking bench for pipe_stage_elastic in both modes
module tb_pipe_stage_elastic;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- stall-mode instance ----------------
  logic        s_rst, s_flush, s_in_valid, s_out_ready;
  logic [5:0]  s_stall;
  logic [31:0] s_in_payload;
  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_payload;
  logic [31:0] s_retire_cnt;

  pipe_stage_elastic #(
    .PAYLOAD_W (32), .MODE (0), .STALL_W (6), .STAGE (4), .CNT_W (32)
  ) u_stall (
    .clk (clk), .rst (s_rst), .flush (s_flush), .stall (s_stall),
    .in_valid (s_in_valid), .in_ready (s_in_ready), .in_payload (s_in_payload),
    .out_valid (s_out_valid), .out_ready (s_out_ready), .out_payload (s_out_payload),
    .retire_cnt (s_retire_cnt)
  );

  // ---------------- elastic-mode instance (4-bit counter) ----------------
  logic        e_rst, e_flush, e_in_valid, e_out_ready;
  logic [5:0]  e_stall;
  logic [31:0] e_in_payload;
  logic        e_in_ready, e_out_valid;
  logic [31:0] e_out_payload;
  logic [3:0]  e_retire_cnt;

  pipe_stage_elastic #(
    .PAYLOAD_W (32), .MODE (1), .STALL_W (6), .STAGE (4), .CNT_W (4)
  ) u_elastic (
    .clk (clk), .rst (e_rst), .flush (e_flush), .stall (e_stall),
    .in_valid (e_in_valid), .in_ready (e_in_ready), .in_payload (e_in_payload),
    .out_valid (e_out_valid), .out_ready (e_out_ready), .out_payload (e_out_payload),
    .retire_cnt (e_retire_cnt)
  );

  // ---------------- stall-mode vector table ----------------
  typedef struct {
    logic [5:0]  stall;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_payload;
    logic        exp_ready;
    logic        exp_valid;
    logic [31:0] exp_payload;
    logic [31:0] exp_cnt;
  } svec_t;

  localparam int NSV = 13;
  svec_t svec [NSV];

  // ---------------- elastic scoreboard ----------------
  logic [31:0] el_q[$];
  logic [3:0]  el_cnt;

  task automatic el_check_outputs();
    logic        exp_valid;
    logic [31:0] exp_pl;
    exp_valid = (el_q.size() > 0);
    exp_pl    = exp_valid ? el_q[0] : 32'h0;
    check("el_in_ready", {63'b0, e_in_ready}, {63'b0, el_q.size() < 2});
    check("el_out_valid", {63'b0, e_out_valid}, {63'b0, exp_valid});
    check("el_out_payload", {32'b0, e_out_payload}, {32'b0, exp_pl});
  endtask

  task automatic el_cycle(input logic v, input logic [31:0] d, input logic ordy,
                          input logic fl, output logic accepted);
    logic fo, fi;
    el_check_outputs();
    e_in_valid   = v;
    e_in_payload = d;
    e_out_ready  = ordy;
    e_flush      = fl;
    fo = (el_q.size() > 0) & ordy;
    fi = v & (el_q.size() < 2);
    @(posedge clk); #1;
    if (fl) begin
      el_q.delete();
    end else begin
      if (fo) begin
        void'(el_q.pop_front());
        el_cnt = el_cnt + 4'd1;
      end
      if (fi) el_q.push_back(d);
    end
    accepted = fi & ~fl;
    check("el_retire_cnt", {60'b0, e_retire_cnt}, {60'b0, el_cnt});
  endtask

  initial begin
    logic        acc;
    logic        saw_block;
    logic [0:9]  ordy_pat;
    int          idx;
    logic [31:0] tag;

    svec[0]  = '{6'b000000, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 32'hDEADBEEF, 32'd0};
    svec[1]  = '{6'b110000, 1'b0, 1'b1, 32'h11111111, 1'b0, 1'b1, 32'hDEADBEEF, 32'd0};
    svec[2]  = '{6'b110000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1, 32'hDEADBEEF, 32'd0};
    svec[3]  = '{6'b000000, 1'b0, 1'b1, 32'h12345678, 1'b1, 1'b1, 32'h12345678, 32'd1};
    svec[4]  = '{6'b010000, 1'b0, 1'b1, 32'h99999999, 1'b0, 1'b0, 32'h00000000, 32'd2};
    svec[5]  = '{6'b000000, 1'b0, 1'b0, 32'h0000AAAA, 1'b1, 1'b0, 32'h00000000, 32'd2};
    svec[6]  = '{6'b000000, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b1, 32'hCAFEF00D, 32'd2};
    svec[7]  = '{6'b000000, 1'b1, 1'b1, 32'h0BADF00D, 1'b1, 1'b0, 32'h00000000, 32'd2};
    svec[8]  = '{6'b100000, 1'b0, 1'b1, 32'h00000055, 1'b1, 1'b1, 32'h00000055, 32'd2};
    svec[9]  = '{6'b110000, 1'b0, 1'b1, 32'h00000056, 1'b0, 1'b1, 32'h00000055, 32'd2};
    svec[10] = '{6'b000000, 1'b0, 1'b1, 32'h00000066, 1'b1, 1'b1, 32'h00000066, 32'd3};
    svec[11] = '{6'b000000, 1'b0, 1'b1, 32'h00000077, 1'b1, 1'b1, 32'h00000077, 32'd4};
    svec[12] = '{6'b000000, 1'b0, 1'b1, 32'h00000088, 1'b1, 1'b1, 32'h00000088, 32'd5};

    s_rst = 1'b1; s_flush = 1'b0; s_stall = 6'b0; s_in_valid = 1'b0;
    s_in_payload = 32'h0; s_out_ready = 1'b0;
    e_rst = 1'b1; e_flush = 1'b0; e_stall = 6'b0; e_in_valid = 1'b0;
    e_in_payload = 32'h0; e_out_ready = 1'b0;
    el_cnt = 4'd0;

    repeat (2) @(posedge clk);
    #1;
    s_rst = 1'b0; e_rst = 1'b0;

    // Reset state
    check("st_reset_valid", {63'b0, s_out_valid}, 64'd0);
    check("st_reset_payload", {32'b0, s_out_payload}, 64'd0);
    check("st_reset_cnt", {32'b0, s_retire_cnt}, 64'd0);
    check("st_reset_ready", {63'b0, s_in_ready}, 64'd1);
    check("el_reset_cnt", {60'b0, e_retire_cnt}, 64'd0);

    // Stall-mode table
    for (int i = 0; i < NSV; i++) begin
      s_stall      = svec[i].stall;
      s_flush      = svec[i].flush;
      s_in_valid   = svec[i].in_valid;
      s_in_payload = svec[i].in_payload;
      #1;
      check($sformatf("st_ready[%0d]", i), {63'b0, s_in_ready}, {63'b0, svec[i].exp_ready});
      @(posedge clk); #1;
      check($sformatf("st_valid[%0d]", i), {63'b0, s_out_valid}, {63'b0, svec[i].exp_valid});
      check($sformatf("st_payload[%0d]", i), {32'b0, s_out_payload}, {32'b0, svec[i].exp_payload});
      check($sformatf("st_cnt[%0d]", i), {32'b0, s_retire_cnt}, {32'b0, svec[i].exp_cnt});
    end
    s_flush = 1'b0;

    // Reset mid-stream with out_valid=1 and retire_cnt=5
    s_rst = 1'b1; s_in_valid = 1'b1; s_in_payload = 32'h99; s_stall = 6'b0;
    @(posedge clk); #1;
    s_rst = 1'b0; s_in_valid = 1'b0;
    check("st_rst_mid_valid", {63'b0, s_out_valid}, 64'd0);
    check("st_rst_mid_payload", {32'b0, s_out_payload}, 64'd0);
    check("st_rst_mid_cnt", {32'b0, s_retire_cnt}, 64'd0);

    // Elastic: stream 1..4 with out_ready low in cycles 2-3
    ordy_pat  = 10'b1100111111;
    idx       = 0;
    saw_block = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (e_in_ready === 1'b0) saw_block = 1'b1;
      el_cycle(idx < 4, (idx < 4) ? 32'(idx + 1) : 32'h0, ordy_pat[c], 1'b0, acc);
      if (acc) idx++;
    end
    el_check_outputs();
    check("el_backpressure_seen", {63'b0, saw_block}, 64'd1);
    check("el_stream_cnt", {60'b0, e_retire_cnt}, 64'd4);

    // Elastic: flush with both entries full and in_valid=1
    el_cycle(1'b1, 32'hA1, 1'b0, 1'b0, acc);
    el_cycle(1'b1, 32'hA2, 1'b0, 1'b0, acc);
    check("el_full_before_flush", {63'b0, e_in_ready}, 64'd0);
    el_cycle(1'b1, 32'hA3, 1'b1, 1'b1, acc);
    check("el_flush_valid", {63'b0, e_out_valid}, 64'd0);
    check("el_flush_ready", {63'b0, e_in_ready}, 64'd1);
    check("el_flush_payload", {32'b0, e_out_payload}, 64'd0);
    check("el_flush_cnt", {60'b0, e_retire_cnt}, 64'd4);
    el_cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);

    // Elastic: reset mid-stream
    el_cycle(1'b1, 32'hB1, 1'b0, 1'b0, acc);
    el_cycle(1'b1, 32'hB2, 1'b0, 1'b0, acc);
    e_rst = 1'b1; e_in_valid = 1'b1; e_in_payload = 32'hB3; e_out_ready = 1'b1;
    @(posedge clk); #1;
    e_rst = 1'b0; e_in_valid = 1'b0;
    el_q.delete();
    el_cnt = 4'd0;
    check("el_rst_valid", {63'b0, e_out_valid}, 64'd0);
    check("el_rst_payload", {32'b0, e_out_payload}, 64'd0);
    check("el_rst_ready", {63'b0, e_in_ready}, 64'd1);
    check("el_rst_cnt", {60'b0, e_retire_cnt}, 64'd0);

    // Elastic: 17 entries at full rate, counter wraps to 1
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      el_cycle(idx < 17, 32'h100 + 32'(idx), 1'b1, 1'b0, acc);
      if (acc) idx++;
    end
    check("el_wrap_accepted", 64'(idx), 64'd17);
    check("el_wrap_cnt", {60'b0, e_retire_cnt}, 64'd1);

    // Elastic: random valid/ready traffic, then drain
    tag = 32'h1000;
    for (int c = 0; c < 60; c++) begin
      el_cycle(1'($urandom_range(0, 1)), tag, 1'($urandom_range(0, 1)), 1'b0, acc);
      if (acc) tag = tag + 32'd1;
    end
    for (int c = 0; c < 4; c++) el_cycle(1'b0, 32'h0, 1'b1, 1'b0, acc);
    el_check_outputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
